// File: rtl/t_debounce_toggle.sv
// t_debounce_toggle
//
// Turns a raw, bouncy push-button into a clean one-cycle toggle pulse per
// accepted press, and keeps a registered toggle state plus a wrap-around count
// of accepted presses.
//
// The button is synchronised through two flops, s1 then s2. A press/release
// state machine then qualifies each level change, so that only s2 reaches it.
//
// Parameters
//   DB_CYCLES  consecutive synchronised samples needed to accept a level
//              change (>= 2)
//   CNT_W      width of the accepted-press counter
//
// Ports
//   clk     sole clock, rising edge
//   rst     synchronous, active-high reset
//   btn     raw button level, asynchronous to clk
//   t       registered one-cycle pulse per accepted press
//   q       registered toggle state, inverts on the edge after t is high
//   qb      ~q
//   tcount  accepted presses modulo 2^CNT_W
//   busy    high while a level change is being qualified
//
// state        | meaning
// -------------+-------------------------------------------------
// IDLE         | button stable released
// PRESS_WAIT   | s2 high, counting samples toward an accepted press
// HELD         | button stable pressed
// RELEASE_WAIT | s2 low, counting samples toward an accepted release

module t_debounce_toggle #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    output logic             t,
    output logic             q,
    output logic             qb,
    output logic [CNT_W-1:0] tcount,
    output logic             busy
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    assign qb = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            t      <= 1'b0;
            q      <= 1'b0;
            tcount <= '0;
            busy   <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            t  <= 1'b0;

            // The pulse registered on the previous edge drives the toggle
            // state and the counter on this edge.
            if (t) begin
                q      <= ~q;
                tcount <= tcount + CNT_W'(1);
            end

            // busy is assigned alongside every state change, so it is a
            // registered decode of the state.
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        t     <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2) begin
                        state <= HELD;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_debounce_toggle.sv
// Directed bench for t_debounce_toggle (DB_CYCLES=4).
// Two instances share the stimulus: one with the default 8-bit counter and
// one with a 2-bit counter, which is used to observe wrap-around.

module tb_t_debounce_toggle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       t, q, qb, busy;
    logic [7:0] tcount;
    logic       t_w, q_w, qb_w, busy_w;
    logic [1:0] tcount_w;

    int n_checks = 0;
    int n_pass   = 0;

    t_debounce_toggle #(.DB_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .t(t), .q(q), .qb(qb), .tcount(tcount), .busy(busy)
    );

    t_debounce_toggle #(.DB_CYCLES(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .btn(btn),
        .t(t_w), .q(q_w), .qb(qb_w), .tcount(tcount_w), .busy(busy_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later and
    // inputs driven here are stable well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int pulses, output int busy_hi);
        pulses  = 0;
        busy_hi = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (t) pulses++;
            if (busy) busy_hi++;
        end
    endtask

    int p, b;
    logic [1:0] wrap_seq [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    initial begin
        // reset state
        rst = 1'b1; btn = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_t", t, 0);
        chk("rst_q", q, 0);
        chk("rst_qb", qb, 1);
        chk("rst_tcount", tcount, 0);
        chk("rst_busy", busy, 0);

        // bounce rejection: three 3-cycle highs
        p = 0; b = 0;
        for (int k = 0; k < 3; k++) begin
            int pp, bb;
            btn = 1'b1; run(3, pp, bb); p += pp; b += bb;
            btn = 1'b0; run(3, pp, bb); p += pp; b += bb;
        end
        begin
            int pp, bb;
            run(8, pp, bb); p += pp;
        end
        chk("bounce_pulses", p, 0);
        chk("bounce_busy_seen", (b > 0), 1);
        chk("bounce_busy_end", busy, 0);
        chk("bounce_q", q, 0);
        chk("bounce_tcount", tcount, 0);

        // clean press with exact latency
        btn = 1'b1;
        tick(); tick();                       // E0, E1
        tick(); chk("press_busy_e2", busy, 1); // E2
        tick(); tick();                       // E3, E4
        chk("press_t_e4", t, 0);
        tick();                               // E5
        chk("press_t_e5", t, 1);
        chk("press_q_e5", q, 0);
        chk("press_busy_e5", busy, 0);
        tick();                               // E6
        chk("press_t_e6", t, 0);
        chk("press_q_e6", q, 1);
        chk("press_qb_e6", qb, 0);
        chk("press_tcount_e6", tcount, 1);
        run(13, p, b);
        chk("hold_pulses", p, 0);

        // release bounce while held
        btn = 1'b0; tick(); tick();
        btn = 1'b1; run(12, p, b);
        chk("relbounce_pulses", p, 0);
        chk("relbounce_busy", busy, 0);
        chk("relbounce_tcount", tcount, 1);

        // clean release, clean press
        btn = 1'b0; run(10, p, b);
        chk("release_pulses", p, 0);
        chk("release_busy", busy, 0);
        btn = 1'b1; run(10, p, b);
        chk("press2_pulses", p, 1);
        chk("press2_q", q, 0);
        chk("press2_tcount", tcount, 2);
        btn = 1'b0; run(10, p, b);

        // wrap with CNT_W=2
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            btn = 1'b1; run(10, p, b);
            chk($sformatf("wrap_tcount_%0d", k), tcount_w, wrap_seq[k]);
            btn = 1'b0; run(10, p, b);
        end
        chk("wrap_q", q_w, 0);
        chk("wrap_tcount8", tcount, 6);

        // reset in PRESS_WAIT with cnt=2
        btn = 1'b1;
        tick(); tick(); tick(); tick();       // E0..E3: PRESS_WAIT, cnt=2
        chk("midq_busy", busy, 1);
        rst = 1'b1; tick();
        chk("midq_t", t, 0);
        chk("midq_q", q, 0);
        chk("midq_qb", qb, 1);
        chk("midq_tcount", tcount, 0);
        chk("midq_busy_rst", busy, 0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("midq_t_after_%0d", i), t, (i == 6) ? 1 : 0);
        end
        chk("midq_q_end", q, 1);
        chk("midq_tcount_end", tcount, 1);

        // reset coinciding with t=1
        rst = 1'b1; btn = 1'b0; tick(); tick(); rst = 1'b0;
        btn = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("coinc_t_pre", t, 1);
        rst = 1'b1; tick();
        chk("coinc_t", t, 0);
        chk("coinc_q", q, 0);
        chk("coinc_tcount", tcount, 0);
        rst = 1'b0; btn = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
